seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 28 ++
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu_mul.sv | 54 +++++
 rtl/seq_alu.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings
// plus the bit positions inside the 4-bit flags word.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_SUB = 3'b000,
    OP_ADD = 3'b001,
    OP_OR  = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_ILL = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // flags = {carry, overflow, zero, negative}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between a client and the sequential ALU.
// slave = ALU side, master = client side.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;
  logic             err;

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, result_hi, flags, err
  );

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, result_hi, flags, err
  );
endinterface

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Only instantiated when SEQ_ALU_MUL_EN is defined.
module seq_alu_mul #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      count_reg;
  logic               running_reg;

  // done is a single-cycle pulse once every multiplier bit has been consumed
  assign done    = running_reg && (count_reg == '0);
  assign product = acc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      count_reg   <= '0;
      running_reg <= 1'b0;
    end else if (start) begin
      acc_reg     <= '0;
      mcand_reg   <= {{WIDTH{1'b0}}, a};
      mplier_reg  <= b;
      count_reg   <= CW'(CYCLES);
      running_reg <= 1'b1;
    end else if (running_reg) begin
      if (count_reg != '0) begin
        if (mplier_reg[0]) begin
          acc_reg <= acc_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg - CW'(1);
      end else begin
        running_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; single-cycle logic/arith ops and
// an optional iterative multiplier enabled by the SEQ_ALU_MUL_EN macro.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam int SHW = $clog2(WIDTH);

  if (WIDTH < 4 || WIDTH > 32 || MUL_CYCLES != WIDTH) begin : g_bad_param
    $error("seq_alu: unsupported WIDTH / MUL_CYCLES combination");
  end

  state_t             state_reg, state_next;
  opcode_t            op;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] shl_wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_err;
  logic [3:0]         alu_flags, mul_flags;

  logic [WIDTH-1:0]   result_reg, result_hi_reg;
  logic [3:0]         flags_reg;
  logic               err_reg;

  assign op     = opcode_t'(bus.opcode);
  assign accept = bus.in_valid && bus.in_ready;

`ifdef SEQ_ALU_MUL_EN
  assign is_mul = (op == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH), .CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  assign bus.in_ready  = !rst && ((state_reg == IDLE) || (state_reg == DONE && bus.out_ready));
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
  assign bus.result_hi = result_hi_reg;
  assign bus.flags     = flags_reg;
  assign bus.err       = err_reg;

  assign sum      = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff     = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
  // the bit just above the kept word is the last one shifted out (0 for shift 0)
  assign shl_wide = {{WIDTH{1'b0}}, bus.a} << bus.b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_SUB: begin
        alu_res = diff[MSB:0];
        alu_c   = diff[WIDTH];
        alu_v   = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      OP_ADD: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_OR:   alu_res = bus.a | bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res = shl_wide[MSB:0];
        alu_c   = shl_wide[WIDTH];
      end
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[MSB];
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_product == '0);
    mul_flags[FLAG_N] = mul_product[MSB];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = is_mul ? BUSY : DONE;
`ifdef SEQ_ALU_MUL_EN
      BUSY: if (mul_done) state_next = DONE;
`endif
      DONE: begin
        if (accept)             state_next = is_mul ? BUSY : DONE;
        else if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // result registers change only on a new capture, so they hold under back-pressure
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      result_reg    <= '0;
      result_hi_reg <= '0;
      flags_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept && !is_mul) begin
        result_reg    <= alu_res;
        result_hi_reg <= '0;
        flags_reg     <= alu_flags;
        err_reg       <= alu_err;
      end else if (state_reg == BUSY && mul_done) begin
        result_reg    <= mul_product[MSB:0];
        result_hi_reg <= mul_product[2*WIDTH-1:WIDTH];
        flags_reg     <= mul_flags;
        err_reg       <= 1'b0;
      end
    end
  end

endmodule
